sdram_axi_apb_bridge: RTL and testbench
=======================================

// Module: sdram_axi_apb_bridge
// PURPOSE
//   AXI4 slave -> APB3/4 master bridge that sits directly upstream of the APB SDRAM
//   controller wrapper and drives its in_p* port. It splits AXI4 bursts (FIXED/INCR/WRAP)
//   into single-beat APB transfers and carries one transaction at a time. It returns
//   per-beat R responses and one aggregated B response per write burst.
// PARAMETERS
//   ID_W     4   width of AXI awid/bid/arid/rid
//   ADDR_W  32   width of AXI/APB address
// PORTS
//   clock          in   1       clock
//   reset          in   1       reset, synchronous, active-high
//   s_awvalid/awready in/out 1  AW handshake
//   s_awid         in   ID_W    write ID
//   s_awaddr       in   ADDR_W  write start address
//   s_awlen        in   8       beats-1
//   s_awsize       in   3       log2 bytes/beat, only 0..2 legal
//   s_awburst      in   2       0 FIXED, 1 INCR, 2 WRAP
//   s_awprot       in   3       forwarded to pprot
//   s_wvalid/wready in/out 1    W handshake
//   s_wdata        in   32      write data
//   s_wstrb        in   4       byte strobes
//   s_wlast        in   1       last write beat
//   s_bvalid/bready out/in 1    B handshake
//   s_bid          out  ID_W    = captured awid
//   s_bresp        out  2       00 OKAY, 10 SLVERR
//   s_ar*          in/out       AR channel, same fields as AW (arid, araddr, arlen, arsize, arburst, arprot)
//   s_rvalid/rready out/in 1    R handshake
//   s_rid          out  ID_W    = captured arid
//   s_rdata        out  32      registered prdata
//   s_rresp        out  2       per-beat: 00 OKAY, 10 SLVERR
//   s_rlast        out  1       high on final beat
//   m_paddr        out  ADDR_W  APB address
//   m_psel         out  1       APB select
//   m_penable      out  1       APB enable
//   m_pwrite       out  1       APB direction
//   m_pprot        out  3       APB protection
//   m_pwdata       out  32      APB write data
//   m_pstrb        out  4       APB strobes; 0 on reads
//   m_pready       in   1       APB ready
//   m_prdata       in   32      APB read data
//   m_pslverr      in   1       APB error
// BEHAVIOUR
//   Reset: FSM=IDLE. All valid/ready/psel/penable outputs 0. Other outputs 0. prio=WRITE.
//   Reset mid-transaction aborts it: no further APB access and no B/R beat. APB bus
//     returns to idle the cycle after reset.
//   FSM: IDLE, WR_DATA, WR_SETUP, WR_ACCESS, WR_RESP, RD_SETUP, RD_ACCESS, RD_RESP.
//   IDLE: awready/arready are combinational, asserted only in IDLE.
//     - Only one of awvalid/arvalid high: grant it.
//     - Both high: grant prio, and prio flips to the other side after each grant.
//     - AW grant -> WR_DATA. AR grant -> RD_SETUP.
//     - On grant, capture id/addr/len/size/burst/prot and clear err.
//   WR_DATA: wready=1. On the W handshake, latch wdata/wstrb -> WR_SETUP.
//   *_SETUP: psel=1, penable=0, paddr=cur_addr -> *_ACCESS next cycle.
//   *_ACCESS: psel=1, penable=1. Hold until pready.
//     - Write: err|=pslverr. Then go to WR_DATA if beats remain, else WR_RESP.
//     - Read: rdata<=prdata, rresp<=pslverr?10:00 -> RD_RESP.
//   RD_RESP: rvalid=1, rlast=(beat==len). On rready:
//     - last beat -> IDLE;
//     - otherwise advance address -> RD_SETUP.
//   WR_RESP: bvalid=1, bresp=err?10:00. On bready -> IDLE.
//   Read latency: AR handshake cycle 0, SETUP cycle 1, ACCESS cycle 2.
//     - If pready=1 in cycle 2, rvalid rises in cycle 3.
//     - Each wait state adds 1 cycle.
//   Address advance after each beat, inc = 1<<size:
//     - FIXED: unchanged.
//     - INCR: cur+inc, full ADDR_W modulo add.
//     - WRAP: mask=((len+1)<<size)-1; next=(cur&~mask)|((cur+inc)&mask).
//   Beat counter 8 bits, compared to len. len=0 gives a single beat. len=255 gives 256 beats.
//   wlast is ignored for sequencing (counter rules). The beat count is taken from len.
//   Outputs are stable while valid is high and ready is low.
//   APB signals are held stable from SETUP until pready.
// TESTING
//   INCR read, araddr=0x8000_0000, len=3, size=2, pready=1 -> paddr 0x..00/04/08/0C; 4 R beats; rlast on beat 4 only; rid=arid.
//   WRAP write, awaddr=0x8000_0038, len=3, size=2 -> paddr 38,3C,30,34; pstrb=wstrb per beat; single B with OKAY.
//   pslverr=1 on beat 2 of a 3-beat write -> bresp=10. Same case on a read -> only beat 2 rresp=10.
//   awvalid and arvalid together from IDLE after reset -> write granted first, next simultaneous request grants read.
//   rready held low 5 cycles, pready delayed 3 cycles -> no new APB setup until the R handshake; rdata stable.
//   reset asserted in RD_ACCESS -> next cycle psel=0, rvalid=0, arready=0; a new AR after reset completes normally.

Source files
------------

// File: rtl/sdram_axi_apb_bridge_if.sv
// Bus bundle between an AXI4 master, the AXI->APB bridge and the APB SDRAM controller wrapper.
// The bridge takes the slave view (AXI slave side, APB master side); the environment takes master.
interface sdram_axi_apb_bridge_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
);
    logic              s_awvalid;
    logic              s_awready;
    logic [ID_W-1:0]   s_awid;
    logic [ADDR_W-1:0] s_awaddr;
    logic [7:0]        s_awlen;
    logic [2:0]        s_awsize;
    logic [1:0]        s_awburst;
    logic [2:0]        s_awprot;

    logic              s_wvalid;
    logic              s_wready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wlast;

    logic              s_bvalid;
    logic              s_bready;
    logic [ID_W-1:0]   s_bid;
    logic [1:0]        s_bresp;

    logic              s_arvalid;
    logic              s_arready;
    logic [ID_W-1:0]   s_arid;
    logic [ADDR_W-1:0] s_araddr;
    logic [7:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic [2:0]        s_arprot;

    logic              s_rvalid;
    logic              s_rready;
    logic [ID_W-1:0]   s_rid;
    logic [31:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;

    logic [ADDR_W-1:0] m_paddr;
    logic              m_psel;
    logic              m_penable;
    logic              m_pwrite;
    logic [2:0]        m_pprot;
    logic [31:0]       m_pwdata;
    logic [3:0]        m_pstrb;
    logic              m_pready;
    logic [31:0]       m_prdata;
    logic              m_pslverr;

    modport slave (
        input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awprot,
        output s_awready,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_wready,
        output s_bvalid, s_bid, s_bresp,
        input  s_bready,
        input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arprot,
        output s_arready,
        output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
        input  s_rready,
        output m_paddr, m_psel, m_penable, m_pwrite, m_pprot, m_pwdata, m_pstrb,
        input  m_pready, m_prdata, m_pslverr
    );

    modport master (
        output s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awprot,
        input  s_awready,
        output s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_wready,
        input  s_bvalid, s_bid, s_bresp,
        output s_bready,
        output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arprot,
        input  s_arready,
        input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
        output s_rready,
        input  m_paddr, m_psel, m_penable, m_pwrite, m_pprot, m_pwdata, m_pstrb,
        output m_pready, m_prdata, m_pslverr
    );
endinterface

// File: rtl/sdram_axi_apb_bridge.sv
// AXI4 slave to APB master bridge: one transaction at a time, bursts split into single APB beats,
// per-beat R responses and one aggregated B response per write burst.
module sdram_axi_apb_bridge #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input logic                   clock,
    input logic                   reset,
    sdram_axi_apb_bridge_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrSetup,
        StWrAccess,
        StWrResp,
        StRdSetup,
        StRdAccess,
        StRdResp
    } state_t;

    state_t state_q, state_d;

    logic              prio_q;  // 0: write wins a tie, 1: read wins
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [2:0]        prot_q;
    logic              err_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       rdata_q;
    logic              rerr_q;

    logic              aw_grant;
    logic              ar_grant;
    logic              last_beat;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] addr_sum;
    logic [ADDR_W-1:0] next_addr;
    logic              unused_wlast;

    // Burst length comes from len alone; wlast carries no sequencing information here.
    assign unused_wlast = bus.s_wlast;

    assign aw_grant  = bus.s_awvalid & (~bus.s_arvalid | ~prio_q);
    assign ar_grant  = bus.s_arvalid & (~bus.s_awvalid | prio_q);
    assign last_beat = (beat_q == len_q);

    assign inc       = ADDR_W'(1) << size_q;
    assign wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    assign addr_sum  = addr_q + inc;

    always_comb begin
        case (burst_q)
            2'd0:    next_addr = addr_q;
            2'd2:    next_addr = (addr_q & ~wrap_mask) | (addr_sum & wrap_mask);
            default: next_addr = addr_sum;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (aw_grant) begin
                    state_d = StWrData;
                end else if (ar_grant) begin
                    state_d = StRdSetup;
                end
            end
            StWrData: begin
                if (bus.s_wvalid) begin
                    state_d = StWrSetup;
                end
            end
            StWrSetup:  state_d = StWrAccess;
            StWrAccess: begin
                if (bus.m_pready) begin
                    state_d = last_beat ? StWrResp : StWrData;
                end
            end
            StWrResp: begin
                if (bus.s_bready) begin
                    state_d = StIdle;
                end
            end
            StRdSetup:  state_d = StRdAccess;
            StRdAccess: begin
                if (bus.m_pready) begin
                    state_d = StRdResp;
                end
            end
            StRdResp: begin
                if (bus.s_rready) begin
                    state_d = last_beat ? StIdle : StRdSetup;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.s_awready = 1'b0;
        bus.s_arready = 1'b0;
        bus.s_wready  = 1'b0;
        bus.s_bvalid  = 1'b0;
        bus.s_rvalid  = 1'b0;
        bus.s_rlast   = 1'b0;
        bus.m_psel    = 1'b0;
        bus.m_penable = 1'b0;
        bus.m_pwrite  = 1'b0;
        case (state_q)
            StIdle: begin
                bus.s_awready = aw_grant & ~reset;
                bus.s_arready = ar_grant & ~reset;
            end
            StWrData: bus.s_wready = 1'b1;
            StWrSetup: begin
                bus.m_psel   = 1'b1;
                bus.m_pwrite = 1'b1;
            end
            StWrAccess: begin
                bus.m_psel    = 1'b1;
                bus.m_penable = 1'b1;
                bus.m_pwrite  = 1'b1;
            end
            StWrResp:  bus.s_bvalid = 1'b1;
            StRdSetup: bus.m_psel = 1'b1;
            StRdAccess: begin
                bus.m_psel    = 1'b1;
                bus.m_penable = 1'b1;
            end
            StRdResp: begin
                bus.s_rvalid = 1'b1;
                bus.s_rlast  = last_beat;
            end
            default: ;
        endcase
        bus.s_bid    = id_q;
        bus.s_bresp  = {err_q, 1'b0};
        bus.s_rid    = id_q;
        bus.s_rdata  = rdata_q;
        bus.s_rresp  = {rerr_q, 1'b0};
        bus.m_paddr  = addr_q;
        bus.m_pprot  = prot_q;
        bus.m_pwdata = wdata_q;
        bus.m_pstrb  = bus.m_pwrite ? wstrb_q : 4'h0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q  <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            prot_q  <= '0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (aw_grant || ar_grant) begin
                        // The side that lost (or was absent) wins the next tie.
                        prio_q <= aw_grant;
                        err_q  <= 1'b0;
                        beat_q <= '0;
                        if (aw_grant) begin
                            id_q    <= bus.s_awid;
                            addr_q  <= bus.s_awaddr;
                            len_q   <= bus.s_awlen;
                            size_q  <= bus.s_awsize;
                            burst_q <= bus.s_awburst;
                            prot_q  <= bus.s_awprot;
                        end else begin
                            id_q    <= bus.s_arid;
                            addr_q  <= bus.s_araddr;
                            len_q   <= bus.s_arlen;
                            size_q  <= bus.s_arsize;
                            burst_q <= bus.s_arburst;
                            prot_q  <= bus.s_arprot;
                        end
                    end
                end
                StWrData: begin
                    if (bus.s_wvalid) begin
                        wdata_q <= bus.s_wdata;
                        wstrb_q <= bus.s_wstrb;
                    end
                end
                StWrAccess: begin
                    if (bus.m_pready) begin
                        err_q <= err_q | bus.m_pslverr;
                        if (!last_beat) begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= next_addr;
                        end
                    end
                end
                StRdAccess: begin
                    if (bus.m_pready) begin
                        rdata_q <= bus.m_prdata;
                        rerr_q  <= bus.m_pslverr;
                    end
                end
                StRdResp: begin
                    if (bus.s_rready && !last_beat) begin
                        beat_q <= beat_q + 8'd1;
                        addr_q <= next_addr;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_axi_apb_bridge.sv
// Self-checking bench: table of bursts checked through APB/R/B scoreboards, plus arbitration,
// latency and mid-transaction reset sequences.
`timescale 1ns/1ps
module tb_sdram_axi_apb_bridge;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int NVEC   = 12;
    localparam int WAIT_LIMIT = 8000;

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          err_beat;
        int          pwait;
        int          rdelay;
        logic [31:0] exp_last;
        logic [1:0]  exp_bresp;
    } vec_t;
    typedef struct { logic [31:0] addr; bit wr; logic [31:0] data; logic [3:0] strb; } apb_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; bit last; } r_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; bit last; } w_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sdram_axi_apb_bridge_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) bus ();
    sdram_axi_apb_bridge #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    apb_t exp_apb[$];
    r_t   exp_r[$];
    b_t   exp_b[$];
    w_t   wq[$];
    vec_t vecs[NVEC];
    vec_t aw_v, ar_v;

    int errors = 0;
    int checks = 0;
    int err_beat = -1, pwait = 0, rdelay = 0, acc_idx = 0, r_beats = 0, b_count = 0;
    int pcnt = 0, rcnt = 0;
    bit r_hold = 0;
    logic [31:0] r_hold_data, setup_addr, last_addr;
    logic [1:0]  last_bresp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] apb_data(input logic [31:0] a);
        return (a ^ 32'h5A5A_0F0F) + 32'h0000_1111;
    endfunction

    function automatic logic [31:0] beat_addr(input vec_t v, input int k);
        logic [31:0] bytes, total, base, off;
        bytes = 32'd1 << v.size;
        total = (32'(v.len) + 32'd1) * bytes;
        base  = v.addr - (v.addr % total);
        off   = ((v.addr - base) + 32'(k) * bytes) % total;
        case (v.burst)
            2'd0:    return v.addr;
            2'd2:    return base + off;
            default: return v.addr + 32'(k) * bytes;
        endcase
    endfunction

    function automatic vec_t mk(input bit wr, input int id, input logic [31:0] addr, input int len,
                                input int size, input int burst, input int eb, input int pw,
                                input int rd, input logic [31:0] el, input int br);
        vec_t v;
        v.wr = wr; v.id = 4'(id); v.addr = addr; v.len = 8'(len); v.size = 3'(size);
        v.burst = 2'(burst); v.err_beat = eb; v.pwait = pw; v.rdelay = rd;
        v.exp_last = el; v.exp_bresp = 2'(br);
        return v;
    endfunction

    // APB completer, AXI R/B/W masters and monitors; decisions at negedge act on the next posedge.
    always @(negedge clock) begin : env
        apb_t a;
        r_t   r;
        b_t   b;
        if (reset) begin
            bus.m_pready = 1'b0; bus.m_pslverr = 1'b0; bus.m_prdata = '0;
            bus.s_wvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 1'b0;
            bus.s_rready = 1'b0; bus.s_bready = 1'b0;
            pcnt = 0; rcnt = 0; r_hold = 0;
        end else begin
            bus.m_pready = 1'b0;
            bus.m_pslverr = 1'b0;
            if (bus.m_psel && !bus.m_penable) setup_addr = bus.m_paddr;
            if (bus.m_psel && bus.m_penable) begin
                if (pcnt >= pwait) begin
                    bus.m_pready  = 1'b1;
                    bus.m_prdata  = apb_data(bus.m_paddr);
                    bus.m_pslverr = (acc_idx == err_beat);
                end else begin
                    pcnt++;
                end
            end
            if (bus.m_psel && bus.m_penable && bus.m_pready) begin
                pcnt = 0;
                acc_idx++;
                last_addr = bus.m_paddr;
                check("apb_addr_held", 64'(bus.m_paddr), 64'(setup_addr));
                if (exp_apb.size() == 0) begin
                    check("apb_unexpected_access", 64'(1), 64'(0));
                end else begin
                    a = exp_apb.pop_front();
                    check("apb_paddr", 64'(bus.m_paddr), 64'(a.addr));
                    check("apb_pwrite", 64'(bus.m_pwrite), 64'(a.wr));
                    check("apb_pstrb", 64'(bus.m_pstrb), 64'(a.strb));
                    if (a.wr) check("apb_pwdata", 64'(bus.m_pwdata), 64'(a.data));
                end
            end

            bus.s_rready = 1'b0;
            if (bus.s_rvalid) begin
                check("r_no_apb_while_rvalid", 64'(bus.m_psel), 64'(0));
                if (!r_hold) begin
                    r_hold = 1;
                    r_hold_data = bus.s_rdata;
                end
                if (rcnt >= rdelay) begin
                    bus.s_rready = 1'b1;
                    if (rdelay > 0) check("r_rdata_stable", 64'(bus.s_rdata), 64'(r_hold_data));
                    rcnt = 0;
                    r_hold = 0;
                    r_beats++;
                    if (exp_r.size() == 0) begin
                        check("r_unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        r = exp_r.pop_front();
                        check("r_rid", 64'(bus.s_rid), 64'(r.id));
                        check("r_rdata", 64'(bus.s_rdata), 64'(r.data));
                        check("r_rresp", 64'(bus.s_rresp), 64'(r.resp));
                        check("r_rlast", 64'(bus.s_rlast), 64'(r.last));
                    end
                end else begin
                    rcnt++;
                end
            end

            bus.s_bready = bus.s_bvalid;
            if (bus.s_bvalid) begin
                b_count++;
                last_bresp = bus.s_bresp;
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 64'(1), 64'(0));
                end else begin
                    b = exp_b.pop_front();
                    check("b_bid", 64'(bus.s_bid), 64'(b.id));
                    check("b_bresp", 64'(bus.s_bresp), 64'(b.resp));
                end
            end

            if (wq.size() > 0) begin
                bus.s_wvalid = 1'b1;
                bus.s_wdata  = wq[0].data;
                bus.s_wstrb  = wq[0].strb;
                bus.s_wlast  = wq[0].last;
                if (bus.s_wready) void'(wq.pop_front());
            end else begin
                bus.s_wvalid = 1'b0;
            end
        end
    end

    task automatic setup_resp(input vec_t v);
        err_beat = v.err_beat; pwait = v.pwait; rdelay = v.rdelay;
        acc_idx = 0; r_beats = 0; b_count = 0;
    endtask

    task automatic push_exp(input vec_t v, input int idx);
        for (int k = 0; k <= int'(v.len); k++) begin
            apb_t a;
            logic [31:0] d;
            logic [3:0] s;
            bit last;
            last = (k == int'(v.len));
            d = 32'hD000_0000 | (32'(idx) << 16) | 32'(k);
            s = 4'hF ^ 4'(k);
            a.addr = beat_addr(v, k);
            a.wr   = v.wr;
            a.data = v.wr ? d : 32'h0;
            a.strb = v.wr ? s : 4'h0;
            exp_apb.push_back(a);
            if (v.wr) wq.push_back('{data: d, strb: s, last: last});
            else exp_r.push_back('{id: v.id, data: apb_data(a.addr),
                                   resp: (k == v.err_beat) ? 2'b10 : 2'b00, last: last});
        end
        if (v.wr) exp_b.push_back('{id: v.id, resp: (v.err_beat >= 0) ? 2'b10 : 2'b00});
    endtask

    task automatic request(input bit do_w, input bit do_r, output bit got_w, output bit got_r,
                           output bit ok);
        @(negedge clock);
        #1;
        bus.s_awid = aw_v.id; bus.s_awaddr = aw_v.addr; bus.s_awlen = aw_v.len;
        bus.s_awsize = aw_v.size; bus.s_awburst = aw_v.burst; bus.s_awprot = 3'b010;
        bus.s_arid = ar_v.id; bus.s_araddr = ar_v.addr; bus.s_arlen = ar_v.len;
        bus.s_arsize = ar_v.size; bus.s_arburst = ar_v.burst; bus.s_arprot = 3'b001;
        bus.s_awvalid = do_w;
        bus.s_arvalid = do_r;
        ok = 0; got_w = 0; got_r = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.s_awready || bus.s_arready) begin
                got_w = bus.s_awready;
                got_r = bus.s_arready;
                @(posedge clock);
                #1;
                ok = 1;
                break;
            end
            @(negedge clock);
            #1;
        end
        bus.s_awvalid = 1'b0;
        bus.s_arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_apb.size() != 0 || exp_r.size() != 0 || exp_b.size() != 0 || wq.size() != 0)
               && n < WAIT_LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("wait_timeout", 64'(n >= WAIT_LIMIT), 64'(0));
        exp_apb.delete(); exp_r.delete(); exp_b.delete(); wq.delete();
        repeat (2) @(negedge clock);
        #1;
    endtask

    task automatic finish_checks(input vec_t v);
        check("last_paddr", 64'(last_addr), 64'(v.exp_last));
        if (v.wr) begin
            check("b_count", 64'(b_count), 64'(1));
            check("b_final_resp", 64'(last_bresp), 64'(v.exp_bresp));
        end else begin
            check("r_beat_count", 64'(r_beats), 64'(int'(v.len) + 1));
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit gw, gr, ok;
        setup_resp(v);
        if (v.wr) aw_v = v;
        else ar_v = v;
        request(v.wr, !v.wr, gw, gr, ok);
        check("grant", 64'({ok, gw, gr}), 64'({1'b1, v.wr, !v.wr}));
        if (ok) begin
            push_exp(v, idx);
            wait_idle();
            finish_checks(v);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit gw, gr, ok;
        int n;
        vec_t v;
        //          wr id  addr           len sz bu err pw rd exp_last       bresp
        vecs[0]  = mk(0, 5, 32'h8000_0000, 3,  2, 1, -1, 0, 0, 32'h8000_000C, 0);
        vecs[1]  = mk(1, 3, 32'h8000_0038, 3,  2, 2, -1, 0, 0, 32'h8000_0034, 0);
        vecs[2]  = mk(1, 7, 32'h0000_0100, 2,  2, 1,  1, 0, 0, 32'h0000_0108, 2);
        vecs[3]  = mk(0, 9, 32'h0000_0200, 2,  2, 1,  1, 0, 0, 32'h0000_0208, 0);
        vecs[4]  = mk(0, 1, 32'h0000_0302, 2,  1, 0, -1, 0, 0, 32'h0000_0302, 0);
        vecs[5]  = mk(1, 2, 32'h0000_0FFF, 0,  0, 1, -1, 0, 0, 32'h0000_0FFF, 0);
        vecs[6]  = mk(0, 4, 32'hFFFF_FFFC, 1,  2, 1, -1, 0, 0, 32'h0000_0000, 0);
        vecs[7]  = mk(0, 6, 32'h0000_1006, 7,  1, 2, -1, 0, 0, 32'h0000_1004, 0);
        vecs[8]  = mk(0, 8, 32'h0000_0400, 1,  2, 1, -1, 3, 5, 32'h0000_0404, 0);
        vecs[9]  = mk(1, 10, 32'h0000_0500, 15, 2, 1, -1, 1, 0, 32'h0000_053C, 0);
        vecs[10] = mk(0, 11, 32'h0000_0040, 255, 2, 0, -1, 0, 0, 32'h0000_0040, 0);
        vecs[11] = mk(1, 12, 32'h0000_2004, 7,  0, 2,  7, 0, 0, 32'h0000_2003, 2);

        reset = 1'b1;
        bus.s_awvalid = 1'b0; bus.s_arvalid = 1'b0;
        aw_v = vecs[1]; ar_v = vecs[0];
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_awready", 64'(bus.s_awready), 64'(0));
        check("rst_arready", 64'(bus.s_arready), 64'(0));
        check("rst_wready", 64'(bus.s_wready), 64'(0));
        check("rst_bvalid_rvalid", 64'({bus.s_bvalid, bus.s_rvalid}), 64'(0));
        check("rst_psel_penable", 64'({bus.m_psel, bus.m_penable}), 64'(0));
        check("rst_paddr", 64'(bus.m_paddr), 64'(0));
        check("rst_pstrb", 64'(bus.m_pstrb), 64'(0));

        // Simultaneous requests: write first after reset, then read on the next tie.
        setup_resp(vecs[1]);
        request(1'b1, 1'b1, gw, gr, ok);
        check("arb_first_write", 64'({ok, gw, gr}), 64'(3'b110));
        if (ok) begin
            push_exp(vecs[1], 1);
            wait_idle();
            finish_checks(vecs[1]);
        end
        setup_resp(vecs[0]);
        request(1'b1, 1'b1, gw, gr, ok);
        check("arb_second_read", 64'({ok, gw, gr}), 64'(3'b101));
        if (ok) begin
            push_exp(vecs[0], 0);
            n = 0;
            while (!bus.s_rvalid && n < 20) begin
                @(posedge clock);
                #1;
                n++;
            end
            check("read_latency_edges", 64'(n), 64'(2));
            wait_idle();
            finish_checks(vecs[0]);
        end

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Reset during a read access phase aborts the burst.
        v = mk(0, 13, 32'h0000_0600, 3, 2, 1, -1, 3, 0, 32'h0000_0600, 0);
        setup_resp(v);
        ar_v = v;
        request(1'b0, 1'b1, gw, gr, ok);
        check("abort_grant", 64'({ok, gr}), 64'(2'b11));
        if (ok) push_exp(v, 13);
        n = 0;
        while (!(bus.m_psel && bus.m_penable) && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("abort_reached_access", 64'(n < 50), 64'(1));
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_psel", 64'(bus.m_psel), 64'(0));
        check("abort_penable", 64'(bus.m_penable), 64'(0));
        check("abort_rvalid", 64'(bus.s_rvalid), 64'(0));
        check("abort_arready", 64'(bus.s_arready), 64'(0));
        exp_apb.delete(); exp_r.delete(); exp_b.delete(); wq.delete();
        @(negedge clock);
        #1;
        reset = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        check("abort_quiet", 64'({bus.m_psel, bus.s_rvalid, bus.s_bvalid}), 64'(0));
        run_vec(mk(0, 14, 32'h0000_0700, 1, 2, 1, -1, 0, 0, 32'h0000_0704, 0), 14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
